stage_sequencer: RTL and testbench
==================================

// Module: stage_sequencer
// PURPOSE
//  Parametrised multicycle stage controller for the MIPS core. Issues one-hot stage enables
//  (fetch..writeBack) one at a time, advances on per-stage done handshakes, owns the PC and
//  retired-instruction count, applies latched branches at retire, and raises endProgram.
//  Sits in mipsProcessor between the top-level clock/start and the fetch/alu/memory/writeBack stages.
// PARAMETERS
//  NUM_STAGES     5   number of sequenced stages (>=2); stage_en bit k enables stage k+1
//  PC_WIDTH       4   width of pc; wraps modulo 2**PC_WIDTH
//  MAX_INSTR      16  instructions retired before endProgram (1..2**16-1)
//  TIMEOUT_CYCLES 15  cycles a stage may stay enabled without done (STAGE_TIMEOUT_EN only)
// PORTS
//  clock          in   1            single clock, all logic on posedge
//  start          in   1            synchronous reset, active-high
//  run            in   1            level; leave IDLE and begin executing at pc
//  stage_done     in   NUM_STAGES   per-stage completion; only bit of enabled stage is used
//  branch_valid   in   1            redirect request from current instruction
//  branch_target  in   PC_WIDTH     redirect address, sampled with branch_valid
//  stage_en       out  NUM_STAGES   one-hot enable of active stage, all-0 when not RUN
//  pc             out  PC_WIDTH     address of instruction in flight
//  instr_count    out  16           instructions retired since start
//  busy           out  1            1 in RUN
//  endProgram     out  1            sticky completion flag, cleared only by start
//  timeout_err    out  1            sticky stage timeout flag (0 when macro off)
// BEHAVIOUR
//  - Reset (start=1 at posedge, highest priority, any state): state=IDLE, stage_en=0, pc=0,
//    instr_count=0, busy=0, endProgram=0, timeout_err=0, branch latch cleared, stage idx=0.
//  - States: IDLE, RUN, DONE. IDLE->RUN on run=1: next cycle stage_en=1 (stage idx 0), busy=1.
//  - RUN: stage_en = 1<<idx. On posedge with stage_done[idx]=1: idx<NUM_STAGES-1 -> idx+1,
//    next stage enabled the following cycle (1-cycle handoff, never two bits set, never a gap
//    state). Done same cycle as enable asserted counts; minimum 1 cycle per stage.
//  - stage_done bits for non-enabled stages ignored; done held high advances one stage per cycle.
//  - branch_valid=1 in any RUN cycle latches branch_target (last one wins); applied at retire.
//  - Retire (done on idx NUM_STAGES-1): pc <= latched ? target : pc+1 (wraps 2**PC_WIDTH-1 -> 0);
//    latch cleared; instr_count+1; idx=0. branch_valid in the retire cycle itself is honoured.
//  - If retiring instruction makes instr_count==MAX_INSTR: ->DONE next cycle, stage_en=0,
//    busy=0, endProgram=1. Else continue at stage idx 0 (run ignored while RUN).
//  - DONE: all outputs hold; run ignored; exit only via start.
//  - run deassert mid-instruction has no effect; sequencing stops only at MAX_INSTR or start.
// CONFIGURATION
//  STAGE_TIMEOUT_EN defined: per-stage cycle counter, cleared on every stage advance. If the
//   enabled stage sees no done for TIMEOUT_CYCLES consecutive enabled cycles: timeout_err=1,
//   endProgram=1, ->DONE next cycle, instr_count/pc frozen (aborted instruction not retired).
//  Undefined: no counter, stage waits indefinitely, timeout_err tied 0.
// TESTING
//  1 start=1 two cycles with run/done toggling -> all outputs 0, state IDLE.
//  2 run=1, stage_done=5'b11111 held -> stage_en 00001,00010,00100,01000,10000 on consecutive
//    cycles, pc 0->1 at retire, instr_count=1, no idle cycle between instructions.
//  3 pc=15 retire, no branch -> pc=0; branch_valid=1 target=4'd9 during stage 3 -> next pc=9.
//  4 MAX_INSTR=3, done always high -> endProgram=1 after 15 enabled cycles, stage_en=0, busy=0,
//    stays through further run pulses until start.
//  5 start=1 while stage_en=00100 -> next cycle outputs at reset values, pc=0.
//  6 STAGE_TIMEOUT_EN, TIMEOUT_CYCLES=15, stage 2 done withheld -> after 15 cycles timeout_err=1,
//    endProgram=1, instr_count unchanged; without macro stage_en stays 00010 indefinitely.

Source files
------------

// File: rtl/stage_sequencer_if.sv
// Stage handshake bundle between the sequencer (master) and the datapath stages (slave).
interface stage_sequencer_if #(
    parameter int NUM_STAGES = 5,
    parameter int PC_WIDTH   = 4
);
    logic [NUM_STAGES-1:0] stage_en;
    logic [NUM_STAGES-1:0] stage_done;
    logic                  branch_valid;
    logic [PC_WIDTH-1:0]   branch_target;

    modport master (
        output stage_en,
        input  stage_done,
        input  branch_valid,
        input  branch_target
    );

    modport slave (
        input  stage_en,
        output stage_done,
        output branch_valid,
        output branch_target
    );
endinterface

// File: rtl/stage_sequencer.sv
// Multicycle stage controller: one-hot stage enables, PC/retire count, branch-at-retire, endProgram.
// Optional per-stage watchdog is enabled with the STAGE_TIMEOUT_EN macro.
//
// state  | meaning
// S_IDLE | after start, waiting for run
// S_RUN  | stepping through stages, stage_en = 1 << idx
// S_DONE | MAX_INSTR retired or stage timed out; frozen until start
module stage_sequencer #(
    parameter int NUM_STAGES     = 5,
    parameter int PC_WIDTH       = 4,
    parameter int MAX_INSTR      = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                clock,
    input  logic                start,
    input  logic                run,
    stage_sequencer_if.master   bus,
    output logic [PC_WIDTH-1:0] pc,
    output logic [15:0]         instr_count,
    output logic                busy,
    output logic                endProgram,
    output logic                timeout_err
);
    localparam int              IDX_W    = $clog2(NUM_STAGES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state, state_nx;
    logic [IDX_W-1:0]    idx, idx_nx;
    logic                stage_hit, retire, last_instr, tmo;
    logic                br_pend;
    logic [PC_WIDTH-1:0] br_tgt, pc_nx;

    assign stage_hit  = (state == S_RUN) && bus.stage_done[idx];
    assign retire     = stage_hit && (idx == LAST_IDX);
    assign last_instr = (instr_count == 16'(MAX_INSTR - 1));

    // A branch seen in the retire cycle itself takes precedence over the latched one.
    assign pc_nx = bus.branch_valid ? bus.branch_target :
                   br_pend          ? br_tgt            : pc + PC_WIDTH'(1);

    assign busy         = (state == S_RUN);
    assign bus.stage_en = (state == S_RUN) ? (NUM_STAGES'(1) << idx) : '0;

`ifdef STAGE_TIMEOUT_EN
    localparam int              TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] tmr;

    assign tmo = (state == S_RUN) && !bus.stage_done[idx] && (tmr == '0);

    always_ff @(posedge clock) begin
        if (start) begin
            tmr         <= TMR_LOAD;
            timeout_err <= 1'b0;
        end else begin
            if (state != S_RUN || stage_hit)
                tmr <= TMR_LOAD;
            else if (tmr != '0)
                tmr <= tmr - TMR_W'(1);
            if (tmo)
                timeout_err <= 1'b1;
        end
    end
`else
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nx = S_RUN;
                    idx_nx   = '0;
                end
            end
            S_RUN: begin
                if (tmo) begin
                    state_nx = S_DONE;
                end else if (stage_hit) begin
                    if (idx == LAST_IDX) begin
                        idx_nx = '0;
                        if (last_instr)
                            state_nx = S_DONE;
                    end else begin
                        idx_nx = idx + IDX_W'(1);
                    end
                end
            end
            S_DONE:  state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (start) begin
            state       <= S_IDLE;
            idx         <= '0;
            pc          <= '0;
            instr_count <= '0;
            br_pend     <= 1'b0;
            br_tgt      <= '0;
            endProgram  <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            if (retire) begin
                pc          <= pc_nx;
                instr_count <= instr_count + 16'd1;
                br_pend     <= 1'b0;
            end else if (state == S_RUN && bus.branch_valid) begin
                br_pend <= 1'b1;
                br_tgt  <= bus.branch_target;
            end
            if (state == S_RUN && state_nx == S_DONE)
                endProgram <= 1'b1;
        end
    end
endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: default instance u1 plus a MAX_INSTR=3 instance u2.
module tb_stage_sequencer;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        start, run, start2, run2;
    logic [3:0]  pc, pc2;
    logic [15:0] cnt, cnt2;
    logic        busy, busy2, endp, endp2, terr, terr2;

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct {
        string       tag;
        logic [4:0]  en;
        logic [3:0]  pc;
        logic [15:0] cnt;
        logic        busy;
        logic        endp;
        logic        terr;
    } exp_t;
    exp_t sb[$];

    stage_sequencer_if #(.NUM_STAGES(5), .PC_WIDTH(4)) bus1 ();
    stage_sequencer_if #(.NUM_STAGES(5), .PC_WIDTH(4)) bus2 ();

    stage_sequencer u1 (
        .clock(clock), .start(start), .run(run), .bus(bus1),
        .pc(pc), .instr_count(cnt), .busy(busy), .endProgram(endp), .timeout_err(terr)
    );

    stage_sequencer #(.MAX_INSTR(3)) u2 (
        .clock(clock), .start(start2), .run(run2), .bus(bus2),
        .pc(pc2), .instr_count(cnt2), .busy(busy2), .endProgram(endp2), .timeout_err(terr2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Push the expected u1 outputs for the coming cycle, clock it, then pop and compare.
    task automatic cyc(input string tag, input logic [4:0] en, input logic [3:0] p,
                       input logic [15:0] c, input logic b, input logic e, input logic t);
        exp_t x;
        x.tag = tag; x.en = en; x.pc = p; x.cnt = c; x.busy = b; x.endp = e; x.terr = t;
        sb.push_back(x);
        step;
        chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            x = sb.pop_front();
            chk({x.tag, "_en"},   32'(bus1.stage_en), 32'(x.en));
            chk({x.tag, "_pc"},   32'(pc),            32'(x.pc));
            chk({x.tag, "_cnt"},  32'(cnt),           32'(x.cnt));
            chk({x.tag, "_busy"}, 32'(busy),          32'(x.busy));
            chk({x.tag, "_endp"}, 32'(endp),          32'(x.endp));
            chk({x.tag, "_terr"}, 32'(terr),          32'(x.terr));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        start = 1'b1; run = 1'b1;
        bus1.stage_done = 5'h1f; bus1.branch_valid = 1'b0; bus1.branch_target = 4'd0;
        start2 = 1'b1; run2 = 1'b0;
        bus2.stage_done = 5'h1f; bus2.branch_valid = 1'b0; bus2.branch_target = 4'd0;

        // reset with run/done active, then toggled
        cyc("rst0", 5'h00, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        run = 1'b0; bus1.stage_done = 5'h00;
        cyc("rst1", 5'h00, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        cyc("idle", 5'h00, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0);

        // done held high: one stage per cycle, back-to-back instructions
        run = 1'b1; bus1.stage_done = 5'h1f;
        cyc("i0_s1", 5'h01, 4'd0, 16'd0, 1'b1, 1'b0, 1'b0);
        run = 1'b0;
        for (int k = 1; k < 5; k++) cyc("i0_s", 5'(1 << k), 4'd0, 16'd0, 1'b1, 1'b0, 1'b0);
        cyc("i1_s1", 5'h01, 4'd1, 16'd1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 5; k++) cyc("i1_s", 5'(1 << k), 4'd1, 16'd1, 1'b1, 1'b0, 1'b0);
        cyc("i2_s1", 5'h01, 4'd2, 16'd2, 1'b1, 1'b0, 1'b0);

        // branch latched during stage 3, applied at retire
        cyc("i2_s2", 5'h02, 4'd2, 16'd2, 1'b1, 1'b0, 1'b0);
        cyc("i2_s3", 5'h04, 4'd2, 16'd2, 1'b1, 1'b0, 1'b0);
        bus1.branch_valid = 1'b1; bus1.branch_target = 4'd9;
        cyc("i2_s4", 5'h08, 4'd2, 16'd2, 1'b1, 1'b0, 1'b0);
        bus1.branch_valid = 1'b0;
        cyc("i2_s5", 5'h10, 4'd2, 16'd2, 1'b1, 1'b0, 1'b0);
        cyc("br9",   5'h01, 4'd9, 16'd3, 1'b1, 1'b0, 1'b0);

        // two branches: later one (in the retire cycle) wins
        cyc("i3_s2", 5'h02, 4'd9, 16'd3, 1'b1, 1'b0, 1'b0);
        bus1.branch_valid = 1'b1; bus1.branch_target = 4'd3;
        cyc("i3_s3", 5'h04, 4'd9, 16'd3, 1'b1, 1'b0, 1'b0);
        bus1.branch_valid = 1'b0;
        cyc("i3_s4", 5'h08, 4'd9, 16'd3, 1'b1, 1'b0, 1'b0);
        cyc("i3_s5", 5'h10, 4'd9, 16'd3, 1'b1, 1'b0, 1'b0);
        bus1.branch_valid = 1'b1; bus1.branch_target = 4'd15;
        cyc("br15",  5'h01, 4'd15, 16'd4, 1'b1, 1'b0, 1'b0);
        bus1.branch_valid = 1'b0;

        // pc wraps 15 -> 0 with latch cleared
        for (int k = 1; k < 5; k++) cyc("i4_s", 5'(1 << k), 4'd15, 16'd4, 1'b1, 1'b0, 1'b0);
        cyc("wrap", 5'h01, 4'd0, 16'd5, 1'b1, 1'b0, 1'b0);

        // done bits of other stages ignored; stage waits without done
        bus1.stage_done = 5'h1e;
        for (int k = 0; k < 3; k++) cyc("ignore", 5'h01, 4'd0, 16'd5, 1'b1, 1'b0, 1'b0);
        bus1.stage_done = 5'h00;
        for (int k = 0; k < 2; k++) cyc("stall", 5'h01, 4'd0, 16'd5, 1'b1, 1'b0, 1'b0);
        bus1.stage_done = 5'h1f;
        cyc("i5_s2", 5'h02, 4'd0, 16'd5, 1'b1, 1'b0, 1'b0);
        cyc("i5_s3", 5'h04, 4'd0, 16'd5, 1'b1, 1'b0, 1'b0);

        // start mid-instruction
        start = 1'b1;
        cyc("rst_mid", 5'h00, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;

        // stage 2 done withheld
        run = 1'b1; bus1.stage_done = 5'h01;
        cyc("to_s1", 5'h01, 4'd0, 16'd0, 1'b1, 1'b0, 1'b0);
        cyc("to_s2", 5'h02, 4'd0, 16'd0, 1'b1, 1'b0, 1'b0);
        run = 1'b0; bus1.stage_done = 5'h00;
`ifdef STAGE_TIMEOUT_EN
        for (int k = 0; k < 14; k++) cyc("to_wait", 5'h02, 4'd0, 16'd0, 1'b1, 1'b0, 1'b0);
        cyc("to_hit",  5'h00, 4'd0, 16'd0, 1'b0, 1'b1, 1'b1);
        run = 1'b1; bus1.stage_done = 5'h1f;
        cyc("to_hold", 5'h00, 4'd0, 16'd0, 1'b0, 1'b1, 1'b1);
`else
        for (int k = 0; k < 20; k++) cyc("no_to", 5'h02, 4'd0, 16'd0, 1'b1, 1'b0, 1'b0);
`endif

        // MAX_INSTR=3 instance: endProgram after 15 enabled cycles, sticky until start
        start2 = 1'b0; run2 = 1'b1;
        step;
        run2 = 1'b0;
        for (int k = 0; k < 15; k++) begin
            chk("m3_en",   32'(bus2.stage_en), 32'(1 << (k % 5)));
            chk("m3_cnt",  32'(cnt2),          32'(k / 5));
            chk("m3_endp", 32'(endp2),         32'd0);
            step;
        end
        for (int k = 0; k < 4; k++) begin
            chk("m3_done_en",   32'(bus2.stage_en), 32'd0);
            chk("m3_done_busy", 32'(busy2),         32'd0);
            chk("m3_done_endp", 32'(endp2),         32'd1);
            chk("m3_done_cnt",  32'(cnt2),          32'd3);
            chk("m3_done_pc",   32'(pc2),           32'd3);
            chk("m3_done_terr", 32'(terr2),         32'd0);
            run2 = ~run2;
            step;
        end
        start2 = 1'b1;
        step;
        chk("m3_rst_endp", 32'(endp2), 32'd0);
        chk("m3_rst_cnt",  32'(cnt2),  32'd0);
        chk("m3_rst_pc",   32'(pc2),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
